// File: rtl/hazard_unit.sv
// Pipeline hazard unit for the five-stage MIPS core: shadows producer info through E/M/W
// and derives the D-stage stall, forwarding selects for D/E/M and a saturating stall counter.
module hazard_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  D_rs,
   input  logic [4:0]  D_rt,
   input  logic [1:0]  D_rs_tuse,
   input  logic [1:0]  D_rt_tuse,
   input  logic [1:0]  D_res,
   input  logic [4:0]  D_dst,
   output logic        stall,
   output logic [1:0]  fwd_D_rs,
   output logic [1:0]  fwd_D_rt,
   output logic [1:0]  fwd_E_rs,
   output logic [1:0]  fwd_E_rt,
   output logic [1:0]  fwd_M_rt,
   output logic [15:0] stall_cnt
);

   localparam logic [1:0] RES_NW  = 2'b00;
   localparam logic [1:0] RES_ALU = 2'b01;
   localparam logic [1:0] RES_DM  = 2'b10;
   localparam logic [1:0] RES_PC  = 2'b11;
   localparam logic [1:0] TUSE_NONE = 2'd3;

   logic [1:0] e_res;
   logic [4:0] e_dst;
   logic [4:0] e_rs;
   logic [4:0] e_rt;
   logic [1:0] m_res;
   logic [4:0] m_dst;
   logic [4:0] m_rt;
   logic [1:0] w_res;
   logic [4:0] w_dst;

   function automatic logic hit(input logic [4:0] r, input logic [1:0] res, input logic [4:0] dst);
      return (r != 5'd0) && (res != RES_NW) && (dst == r);
   endfunction

   function automatic logic [1:0] tnew_e(input logic [1:0] res);
      case (res)
         RES_ALU: return 2'd1;
         RES_DM:  return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [1:0] tnew_m(input logic [1:0] res);
      return (res == RES_DM) ? 2'd1 : 2'd0;
   endfunction

   function automatic logic need_stall(input logic [4:0] r, input logic [1:0] tuse,
                                       input logic [1:0] er, input logic [4:0] ed,
                                       input logic [1:0] mr, input logic [4:0] md);
      if (tuse == TUSE_NONE) return 1'b0;
      return (hit(r, er, ed) && (tnew_e(er) > tuse)) ||
             (hit(r, mr, md) && (tnew_m(mr) > tuse));
   endfunction

   // A matching stage that is not ready yet is skipped so the next ready stage is reported.
   function automatic logic [1:0] sel_d(input logic [4:0] r,
                                        input logic [1:0] er, input logic [4:0] ed,
                                        input logic [1:0] mr, input logic [4:0] md,
                                        input logic [1:0] wr, input logic [4:0] wd);
      if (hit(r, er, ed) && (er == RES_PC)) return 2'd3;
      if (hit(r, mr, md) && (mr != RES_DM)) return 2'd1;
      if (hit(r, wr, wd)) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [1:0] sel_e(input logic [4:0] r,
                                        input logic [1:0] mr, input logic [4:0] md,
                                        input logic [1:0] wr, input logic [4:0] wd);
      if (hit(r, mr, md) && (mr != RES_DM)) return 2'd1;
      if (hit(r, wr, wd)) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   always_comb begin
      stall    = need_stall(D_rs, D_rs_tuse, e_res, e_dst, m_res, m_dst) |
                 need_stall(D_rt, D_rt_tuse, e_res, e_dst, m_res, m_dst);
      fwd_D_rs = sel_d(D_rs, e_res, e_dst, m_res, m_dst, w_res, w_dst);
      fwd_D_rt = sel_d(D_rt, e_res, e_dst, m_res, m_dst, w_res, w_dst);
      fwd_E_rs = sel_e(e_rs, m_res, m_dst, w_res, w_dst);
      fwd_E_rt = sel_e(e_rt, m_res, m_dst, w_res, w_dst);
      fwd_M_rt = hit(m_rt, w_res, w_dst) ? 2'd2 : 2'd0;
   end

   // Shadow pipeline advance: D -> E (or bubble) -> M -> W
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_res     <= RES_NW;
         e_dst     <= 5'd0;
         e_rs      <= 5'd0;
         e_rt      <= 5'd0;
         m_res     <= RES_NW;
         m_dst     <= 5'd0;
         m_rt      <= 5'd0;
         w_res     <= RES_NW;
         w_dst     <= 5'd0;
         stall_cnt <= 16'd0;
      end else begin
         w_res <= m_res;
         w_dst <= m_dst;
         m_res <= e_res;
         m_dst <= e_dst;
         m_rt  <= e_rt;
         if (stall) begin
            e_res     <= RES_NW;
            e_dst     <= 5'd0;
            e_rs      <= 5'd0;
            e_rt      <= 5'd0;
            stall_cnt <= sat_inc(stall_cnt);
         end else begin
            e_res <= D_res;
            e_dst <= D_dst;
            e_rs  <= D_rs;
            e_rt  <= D_rt;
         end
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: per-cycle vector table of D inputs with expected
// stall/forward/counter values, plus counter saturation and asynchronous reset sequences.
module tb_hazard_unit;

   localparam int NW = 0, ALU = 1, DM = 2, PC = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  D_rs = '0, D_rt = '0, D_dst = '0;
   logic [1:0]  D_rs_tuse = 2'd3, D_rt_tuse = 2'd3, D_res = '0;
   logic        stall;
   logic [1:0]  fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;
   logic [15:0] stall_cnt;

   hazard_unit dut (
      .clk       (clk),
      .reset     (reset),
      .D_rs      (D_rs),
      .D_rt      (D_rt),
      .D_rs_tuse (D_rs_tuse),
      .D_rt_tuse (D_rt_tuse),
      .D_res     (D_res),
      .D_dst     (D_dst),
      .stall     (stall),
      .fwd_D_rs  (fwd_D_rs),
      .fwd_D_rt  (fwd_D_rt),
      .fwd_E_rs  (fwd_E_rs),
      .fwd_E_rt  (fwd_E_rt),
      .fwd_M_rt  (fwd_M_rt),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [4:0]  rs, rt, dst;
      logic [1:0]  rs_tuse, rt_tuse, res;
      logic        stall;
      logic [1:0]  fdrs, fdrt, fers, fert, fmrt;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic add(input int rst, input int rs, input int rs_tuse, input int rt, input int rt_tuse,
                      input int res, input int dst, input int st, input int fdrs, input int fdrt,
                      input int fers, input int fert, input int fmrt, input int cnt);
      vec_t v;
      v.rst = 1'(rst);      v.rs = 5'(rs);           v.rs_tuse = 2'(rs_tuse);
      v.rt = 5'(rt);        v.rt_tuse = 2'(rt_tuse); v.res = 2'(res);
      v.dst = 5'(dst);      v.stall = 1'(st);        v.fdrs = 2'(fdrs);
      v.fdrt = 2'(fdrt);    v.fers = 2'(fers);       v.fert = 2'(fert);
      v.fmrt = 2'(fmrt);    v.cnt = 16'(cnt);
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input int rs, input int rs_tuse, input int rt, input int rt_tuse,
                        input int res, input int dst);
      D_rs = 5'(rs);   D_rs_tuse = 2'(rs_tuse);
      D_rt = 5'(rt);   D_rt_tuse = 2'(rt_tuse);
      D_res = 2'(res); D_dst = 5'(dst);
   endtask

   task automatic check_all(input int idx, input logic st, input logic [1:0] fdrs, input logic [1:0] fdrt,
                            input logic [1:0] fers, input logic [1:0] fert, input logic [1:0] fmrt,
                            input logic [15:0] cnt);
      check("stall",     idx, 16'(stall),    16'(st));
      check("fwd_D_rs",  idx, 16'(fwd_D_rs), 16'(fdrs));
      check("fwd_D_rt",  idx, 16'(fwd_D_rt), 16'(fdrt));
      check("fwd_E_rs",  idx, 16'(fwd_E_rs), 16'(fers));
      check("fwd_E_rt",  idx, 16'(fwd_E_rt), 16'(fert));
      check("fwd_M_rt",  idx, 16'(fwd_M_rt), 16'(fmrt));
      check("stall_cnt", idx, stall_cnt,     cnt);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // lw $1 ; addu rs=$1
      add(1, 0,3, 0,3, DM,1,   0, 0,0,0,0,0, 0);
      add(0, 1,1, 0,1, ALU,4,  1, 0,0,0,0,0, 0);
      add(0, 1,1, 0,1, ALU,4,  0, 0,0,0,0,0, 1);
      add(0, 0,3, 0,3, NW,0,   0, 0,0,2,0,0, 1);
      add(0, 0,3, 0,3, NW,0,   0, 0,0,0,0,0, 1);
      // lw $2 ; beq rs=$2
      add(1, 0,3, 0,3, DM,2,   0, 0,0,0,0,0, 0);
      add(0, 2,0, 0,0, NW,0,   1, 0,0,0,0,0, 0);
      add(0, 2,0, 0,0, NW,0,   1, 0,0,0,0,0, 1);
      add(0, 2,0, 0,0, NW,0,   0, 2,0,0,0,0, 2);
      add(0, 0,3, 0,3, NW,0,   0, 0,0,0,0,0, 2);
      // addu $3 ; beq rt=$3
      add(1, 0,1, 0,1, ALU,3,  0, 0,0,0,0,0, 0);
      add(0, 0,0, 3,0, NW,0,   1, 0,0,0,0,0, 0);
      add(0, 0,0, 3,0, NW,0,   0, 0,1,0,0,0, 1);
      add(0, 0,3, 0,3, NW,0,   0, 0,0,0,2,0, 1);
      add(0, 0,3, 0,3, NW,0,   0, 0,0,0,0,0, 1);
      // jal ; jr $31 ; nop ; addu rs=$31
      add(1, 0,3, 0,3, PC,31,  0, 0,0,0,0,0, 0);
      add(0, 31,0, 0,3, NW,0,  0, 3,0,0,0,0, 0);
      add(0, 0,3, 0,3, NW,0,   0, 0,0,1,0,0, 0);
      add(0, 31,1, 0,1, ALU,10, 0, 2,0,0,0,0, 0);
      // lw $6 ; sw rt=$6 : store data forwarded into M from W
      add(1, 0,3, 0,3, DM,6,   0, 0,0,0,0,0, 0);
      add(0, 0,1, 6,2, NW,0,   0, 0,0,0,0,0, 0);
      add(0, 0,3, 0,3, NW,0,   0, 0,0,0,0,0, 0);
      add(0, 0,3, 0,3, NW,0,   0, 0,0,0,0,2, 0);
      // writes to $0 never hazard
      add(1, 0,3, 0,3, ALU,0,  0, 0,0,0,0,0, 0);
      add(0, 0,0, 0,0, ALU,0,  0, 0,0,0,0,0, 0);
      add(0, 0,0, 0,0, ALU,0,  0, 0,0,0,0,0, 0);
      add(0, 0,3, 0,3, DM,0,   0, 0,0,0,0,0, 0);
      add(0, 0,0, 0,0, NW,0,   0, 0,0,0,0,0, 0);
      // addu $5 ; lw $5 ; beq $5,$7 : stalled cycles report next ready stage
      add(1, 0,3, 0,3, ALU,5,  0, 0,0,0,0,0, 0);
      add(0, 0,3, 0,3, DM,5,   0, 0,0,0,0,0, 0);
      add(0, 5,0, 7,0, NW,0,   1, 1,0,0,0,0, 0);
      add(0, 5,0, 7,0, NW,0,   1, 2,0,0,0,0, 1);
      add(0, 5,0, 7,0, NW,0,   0, 2,0,0,0,0, 2);
      // addu $8 ; lw $9 ; addu rs=$8 rt=$9 : independent rs/rt resolution
      add(1, 0,3, 0,3, ALU,8,  0, 0,0,0,0,0, 0);
      add(0, 0,3, 0,3, DM,9,   0, 0,0,0,0,0, 0);
      add(0, 8,1, 9,1, ALU,11, 1, 1,0,0,0,0, 0);
      add(0, 8,1, 9,1, ALU,11, 0, 2,0,0,0,0, 1);
      add(0, 0,3, 0,3, NW,0,   0, 0,0,0,2,0, 1);

      // reset state while reset is held
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all(-1, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 16'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      foreach (vecs[i]) begin
         if (vecs[i].rst) begin
            reset = 1'b1; #1; reset = 1'b0;
         end
         drive(int'(vecs[i].rs), int'(vecs[i].rs_tuse), int'(vecs[i].rt), int'(vecs[i].rt_tuse),
               int'(vecs[i].res), int'(vecs[i].dst));
         @(negedge clk);
         check_all(i, vecs[i].stall, vecs[i].fdrs, vecs[i].fdrt, vecs[i].fers, vecs[i].fert,
                   vecs[i].fmrt, vecs[i].cnt);
         @(posedge clk); #1;
      end

      // counter saturation with stall held high for 70000 edges
      reset = 1'b1; #1; reset = 1'b0;
      drive(0, 3, 0, 3, NW, 0);
      @(negedge clk);
      force dut.stall = 1'b1;
      repeat (65534) @(posedge clk);
      @(negedge clk);
      check("sat_before", 0, stall_cnt, 16'hFFFE);
      repeat (70000 - 65534) @(posedge clk);
      @(negedge clk);
      check("sat_hold", 0, stall_cnt, 16'hFFFF);
      release dut.stall;

      // asynchronous reset in the middle of a lw -> beq stall
      @(posedge clk); #1;
      reset = 1'b1; #1; reset = 1'b0;
      drive(0, 3, 0, 3, DM, 2);
      @(posedge clk); #1;
      drive(2, 0, 0, 3, NW, 0);
      @(negedge clk);
      check("ar_stall1", 0, 16'(stall), 16'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("ar_stall2", 0, 16'(stall), 16'd1);
      check("ar_cnt", 0, stall_cnt, 16'd1);
      #2;
      reset = 1'b1;
      #1;
      check_all(100, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 16'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("ar_after", 0, 16'(stall), 16'd0);
      check("ar_after_fwd", 0, 16'(fwd_D_rs), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
